// File: rtl/ctrl_seq_handshake_if.sv
// Control/datapath bundle for the multi-cycle sequencer: instruction and flag
// inputs, memory handshake, and every datapath strobe/select it drives.
interface ctrl_seq_handshake_if #(
  parameter int NUM_REGS = 8
);
  logic                run;
  logic                mem_ready;
  logic [15:0]         ir_out;
  logic [2:0]          flag_out;
  logic                pc_incr;
  logic                ir_in;
  logic                a_in;
  logic                g_in;
  logic                flag_in;
  logic                addr_in;
  logic                dout_in;
  logic                w_en;
  logic [NUM_REGS-1:0] rx_in;
  logic [3:0]          sel;
  logic [1:0]          op;
  logic                add_sub;
  logic [1:0]          shift_type;
  logic                done;
  logic                bus_err;
  logic [3:0]          state_dbg;

  modport master (
    input  run, mem_ready, ir_out, flag_out,
    output pc_incr, ir_in, a_in, g_in, flag_in, addr_in, dout_in, w_en,
           rx_in, sel, op, add_sub, shift_type, done, bus_err, state_dbg
  );

  modport slave (
    output run, mem_ready, ir_out, flag_out,
    input  pc_incr, ir_in, a_in, g_in, flag_in, addr_in, dout_in, w_en,
           rx_in, sel, op, add_sub, shift_type, done, bus_err, state_dbg
  );
endinterface

// File: rtl/ctrl_seq_handshake.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit datapath, with a
// memory-ready handshake, wait timeout into a sticky bus-error trap.
module ctrl_seq_handshake #(
  parameter int NUM_REGS = 8,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ctrl_seq_handshake_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    FWAIT  = 4'd2,
    DECODE = 4'd3,
    EX1    = 4'd4,
    EX2    = 4'd5,
    EX3    = 4'd6,
    MWAIT  = 4'd7,
    LDWB   = 4'd8,
    ERR    = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    OP_MV     = 3'd0,
    OP_MVT_B  = 3'd1,
    OP_ADD    = 3'd2,
    OP_SUB    = 3'd3,
    OP_LD     = 3'd4,
    OP_ST     = 3'd5,
    OP_AND    = 3'd6,
    OP_CMP_SH = 3'd7
  } opcode_t;

  localparam logic [3:0]          SEL_PC    = 4'(NUM_REGS - 1);
  localparam logic [3:0]          SEL_IR    = 4'd8;
  localparam logic [3:0]          SEL_G     = 4'd9;
  localparam logic [3:0]          SEL_DIN   = 4'd10;
  localparam logic [NUM_REGS-1:0] PC_ONEHOT = NUM_REGS'(1) << (NUM_REGS - 1);

  state_t              state, next_state;
  logic [WAIT_W-1:0]   wait_cnt;

  opcode_t             opcode;
  logic                imm;
  logic [2:0]          rx_idx, ry_idx;
  logic [3:0]          rx_sel, ry_sel, src_sel;
  logic                cond_true, timeout, boundary_run;
  logic                unused_ir;

  logic                pc_incr_c, ir_in_c, a_in_c, g_in_c, flag_in_c;
  logic                addr_in_c, dout_in_c, w_en_c, add_sub_c, done_c, bus_err_c;
  logic [NUM_REGS-1:0] rx_en;
  logic [3:0]          sel_c;
  logic [1:0]          op_c, shift_type_c;

  // Indices beyond NUM_REGS-1 have no bit to set, so they write nothing.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [2:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      v[i] = ({29'b0, idx} == i);
    return v;
  endfunction

  assign opcode    = opcode_t'(bus.ir_out[15:13]);
  assign imm       = bus.ir_out[12];
  assign rx_idx    = bus.ir_out[11:9];
  assign ry_idx    = bus.ir_out[2:0];
  assign rx_sel    = {1'b0, rx_idx};
  assign ry_sel    = {1'b0, ry_idx};
  assign src_sel   = imm ? SEL_IR : ry_sel;
  assign timeout   = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
  assign unused_ir = ^bus.ir_out[4:3];
  assign boundary_run = bus.run;

  // flag_out = {carry, negative, zero}; condition code lives in the RX field.
  always_comb begin
    cond_true = 1'b0;
    case (rx_idx)
      3'd0: cond_true = 1'b1;
      3'd1: cond_true = bus.flag_out[0];
      3'd2: cond_true = ~bus.flag_out[0];
      3'd3: cond_true = ~bus.flag_out[2];
      3'd4: cond_true = bus.flag_out[2];
      3'd5: cond_true = ~bus.flag_out[1];
      3'd6: cond_true = bus.flag_out[1];
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= ((state == FWAIT || state == MWAIT) && next_state == state)
                  ? wait_cnt + WAIT_W'(1) : '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (bus.run) next_state = FETCH;
      FETCH:  next_state = FWAIT;
      FWAIT: begin
        if (bus.mem_ready)  next_state = DECODE;
        else if (timeout)   next_state = ERR;
      end
      DECODE: next_state = EX1;
      EX1: begin
        if (done_c)                next_state = boundary_run ? FETCH : IDLE;
        else if (opcode == OP_LD)  next_state = MWAIT;
        else                       next_state = EX2;
      end
      EX2: begin
        if (done_c)                next_state = boundary_run ? FETCH : IDLE;
        else if (opcode == OP_ST)  next_state = MWAIT;
        else                       next_state = EX3;
      end
      EX3:    next_state = boundary_run ? FETCH : IDLE;
      MWAIT: begin
        if (bus.mem_ready)
          next_state = (opcode == OP_LD) ? LDWB : (boundary_run ? FETCH : IDLE);
        else if (timeout)
          next_state = ERR;
      end
      LDWB:   next_state = boundary_run ? FETCH : IDLE;
      ERR:    next_state = ERR;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pc_incr_c    = 1'b0;
    ir_in_c      = 1'b0;
    a_in_c       = 1'b0;
    g_in_c       = 1'b0;
    flag_in_c    = 1'b0;
    addr_in_c    = 1'b0;
    dout_in_c    = 1'b0;
    w_en_c       = 1'b0;
    add_sub_c    = 1'b0;
    done_c       = 1'b0;
    bus_err_c    = 1'b0;
    rx_en        = '0;
    sel_c        = '0;
    op_c         = '0;
    shift_type_c = '0;
    case (state)
      FETCH: begin
        sel_c     = SEL_PC;
        addr_in_c = 1'b1;
        pc_incr_c = 1'b1;
      end
      DECODE: ir_in_c = 1'b1;
      EX1: begin
        case (opcode)
          OP_MV: begin
            sel_c  = src_sel;
            rx_en  = reg_onehot(rx_idx);
            done_c = 1'b1;
          end
          OP_MVT_B: begin
            if (imm) begin
              sel_c  = SEL_IR;
              rx_en  = reg_onehot(rx_idx);
              done_c = 1'b1;
            end else begin
              sel_c  = SEL_PC;
              a_in_c = 1'b1;
              done_c = ~cond_true;
            end
          end
          OP_LD, OP_ST: begin
            sel_c     = ry_sel;
            addr_in_c = 1'b1;
          end
          default: begin
            sel_c  = rx_sel;
            a_in_c = 1'b1;
          end
        endcase
      end
      EX2: begin
        case (opcode)
          OP_MVT_B: begin
            sel_c  = SEL_IR;
            g_in_c = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel_c     = src_sel;
            g_in_c    = 1'b1;
            flag_in_c = 1'b1;
            add_sub_c = (opcode == OP_SUB);
            op_c      = (opcode == OP_AND) ? 2'd1 : 2'd0;
          end
          OP_ST: begin
            sel_c     = rx_sel;
            dout_in_c = 1'b1;
            w_en_c    = 1'b1;
          end
          OP_CMP_SH: begin
            flag_in_c = 1'b1;
            if (imm || !bus.ir_out[8]) begin
              sel_c     = src_sel;
              add_sub_c = 1'b1;
              done_c    = 1'b1;
            end else begin
              sel_c        = bus.ir_out[7] ? SEL_IR : ry_sel;
              op_c         = 2'd2;
              shift_type_c = bus.ir_out[6:5];
              g_in_c       = 1'b1;
            end
          end
          default: ;
        endcase
      end
      EX3: begin
        sel_c  = SEL_G;
        rx_en  = (opcode == OP_MVT_B) ? PC_ONEHOT : reg_onehot(rx_idx);
        done_c = 1'b1;
      end
      MWAIT:  done_c = (opcode == OP_ST) && bus.mem_ready;
      LDWB: begin
        sel_c  = SEL_DIN;
        rx_en  = reg_onehot(rx_idx);
        done_c = 1'b1;
      end
      ERR:    bus_err_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_incr    = pc_incr_c;
  assign bus.ir_in      = ir_in_c;
  assign bus.a_in       = a_in_c;
  assign bus.g_in       = g_in_c;
  assign bus.flag_in    = flag_in_c;
  assign bus.addr_in    = addr_in_c;
  assign bus.dout_in    = dout_in_c;
  assign bus.w_en       = w_en_c;
  assign bus.rx_in      = rx_en;
  assign bus.sel        = sel_c;
  assign bus.op         = op_c;
  assign bus.add_sub    = add_sub_c;
  assign bus.shift_type = shift_type_c;
  assign bus.done       = done_c;
  assign bus.bus_err    = bus_err_c;
  assign bus.state_dbg  = state;

endmodule
